// File: rtl/reg_file_cmd_ctrl_if.sv
// Bus bundle between the command controller and its neighbours: RX byte stream,
// register-file write/read port, TX byte handshake and status flags.
interface reg_file_cmd_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int ADDR  = 4
);
   logic [WIDTH-1:0] rx_data_in;
   logic             rx_valid_in;
   logic             rf_wr_en_out;
   logic             rf_rd_en_out;
   logic [ADDR-1:0]  rf_addr_out;
   logic [WIDTH-1:0] rf_wr_data_out;
   logic [WIDTH-1:0] rf_rd_data_in;
   logic             rf_rd_data_valid_in;
   logic [WIDTH-1:0] tx_data_out;
   logic             tx_valid_out;
   logic             tx_ready_in;
   logic             busy_out;
   logic             err_out;

   modport master (
      input  rx_data_in, rx_valid_in, rf_rd_data_in, rf_rd_data_valid_in, tx_ready_in,
      output rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out,
             tx_data_out, tx_valid_out, busy_out, err_out
   );

   modport slave (
      output rx_data_in, rx_valid_in, rf_rd_data_in, rf_rd_data_valid_in, tx_ready_in,
      input  rf_wr_en_out, rf_rd_en_out, rf_addr_out, rf_wr_data_out,
             tx_data_out, tx_valid_out, busy_out, err_out
   );
endinterface

// File: rtl/reg_file_cmd_ctrl.sv
// Decodes write/read command frames from the RX byte stream into register-file
// accesses and returns read data on TX. Optional read timeout: CTRL_TIMEOUT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for an opcode byte
// S_W_ADDR | write frame, waiting for address byte
// S_W_DATA | write frame, waiting for data byte
// S_R_ADDR | read frame, waiting for address byte
// S_R_WAIT | read issued, waiting for register-file data
// S_TX     | read byte offered on TX until accepted
module reg_file_cmd_ctrl #(
   parameter int               WIDTH  = 8,
   parameter int               ADDR   = 4,
   parameter logic [WIDTH-1:0] WR_CMD = 8'hAA,
   parameter logic [WIDTH-1:0] RD_CMD = 8'hBB
`ifdef CTRL_TIMEOUT_EN
   ,
   parameter int               TIMEOUT  = 16,
   parameter logic [WIDTH-1:0] ERR_BYTE = 8'hEE
`endif
) (
   input  logic                clk,
   input  logic                reset_n,
   reg_file_cmd_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_W_ADDR, S_W_DATA, S_R_ADDR, S_R_WAIT, S_TX
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [ADDR-1:0]  r_addr, w_addr_nxt;
   logic [WIDTH-1:0] r_wr_data, w_wr_data_nxt;
   logic             r_wr_en, w_wr_en_nxt;
   logic             r_rd_en, w_rd_en_nxt;
   logic [WIDTH-1:0] r_tx_data, w_tx_data_nxt;
   logic             r_tx_valid, w_tx_valid_nxt;
   logic             r_busy;
   logic             r_err, w_err_nxt;

`ifdef CTRL_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_tmo_cnt <= '0;
      else          r_tmo_cnt <= w_tmo_cnt_nxt;
   end
`else
   // Without the timeout option R_WAIT simply parks until read data shows up.
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_wr_data  <= '0;
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
         r_wr_en    <= w_wr_en_nxt;
         r_rd_en    <= w_rd_en_nxt;
         r_tx_data  <= w_tx_data_nxt;
         r_tx_valid <= w_tx_valid_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_wr_data_nxt  = r_wr_data;
      w_wr_en_nxt    = 1'b0;
      w_rd_en_nxt    = 1'b0;
      w_tx_data_nxt  = r_tx_data;
      w_tx_valid_nxt = r_tx_valid;
      w_err_nxt      = 1'b0;
`ifdef CTRL_TIMEOUT_EN
      w_tmo_cnt_nxt  = r_tmo_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (bus.rx_valid_in) begin
               if (bus.rx_data_in == WR_CMD)      w_state_nxt = S_W_ADDR;
               else if (bus.rx_data_in == RD_CMD) w_state_nxt = S_R_ADDR;
               else                               w_err_nxt   = 1'b1;
            end
         end
         S_W_ADDR: begin
            if (bus.rx_valid_in) begin
               w_addr_nxt  = bus.rx_data_in[ADDR-1:0];
               w_state_nxt = S_W_DATA;
            end
         end
         S_W_DATA: begin
            if (bus.rx_valid_in) begin
               w_wr_data_nxt = bus.rx_data_in;
               w_wr_en_nxt   = 1'b1;
               w_state_nxt   = S_IDLE;
            end
         end
         S_R_ADDR: begin
            if (bus.rx_valid_in) begin
               w_addr_nxt  = bus.rx_data_in[ADDR-1:0];
               w_rd_en_nxt = 1'b1;
               w_state_nxt = S_R_WAIT;
`ifdef CTRL_TIMEOUT_EN
               w_tmo_cnt_nxt = '0;
`endif
            end
         end
         S_R_WAIT: begin
            if (bus.rx_valid_in) w_err_nxt = 1'b1;
            if (bus.rf_rd_data_valid_in) begin
               w_tx_data_nxt  = bus.rf_rd_data_in;
               w_tx_valid_nxt = 1'b1;
               w_state_nxt    = S_TX;
            end
`ifdef CTRL_TIMEOUT_EN
            // Counter holds the number of full R_WAIT cycles already spent.
            else if (r_tmo_cnt == CW'(TIMEOUT - 1)) begin
               w_tx_data_nxt  = ERR_BYTE;
               w_tx_valid_nxt = 1'b1;
               w_err_nxt      = 1'b1;
               w_state_nxt    = S_TX;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + CW'(1);
            end
`endif
         end
         S_TX: begin
            if (bus.rx_valid_in) w_err_nxt = 1'b1;
            if (r_tx_valid && bus.tx_ready_in) begin
               w_tx_valid_nxt = 1'b0;
               w_state_nxt    = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.rf_wr_en_out   = r_wr_en;
   assign bus.rf_rd_en_out   = r_rd_en;
   assign bus.rf_addr_out    = r_addr;
   assign bus.rf_wr_data_out = r_wr_data;
   assign bus.tx_data_out    = r_tx_data;
   assign bus.tx_valid_out   = r_tx_valid;
   assign bus.busy_out       = r_busy;
   assign bus.err_out        = r_err;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Bench for reg_file_cmd_ctrl: directed frame scenarios plus a randomized frame
// stream checked against a transaction-level model (writes, read bytes, errors).
module tb_reg_file_cmd_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_cmd_ctrl_if #(.WIDTH(8), .ADDR(4)) ifc();

   reg_file_cmd_ctrl #(
      .WIDTH(8), .ADDR(4), .WR_CMD(8'hAA), .RD_CMD(8'hBB)
`ifdef CTRL_TIMEOUT_EN
      , .TIMEOUT(16), .ERR_BYTE(8'hEE)
`endif
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(ifc)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // register-file stub with programmable read latency
   logic [7:0] stub_mem [16] = '{default: 8'h00};
   int         stub_cnt = 0;
   logic [3:0] stub_addr = 4'h0;
   int         rd_lat = 1;
   bit         rf_never = 1'b0;

   always @(posedge clk) begin
      ifc.rf_rd_data_valid_in <= 1'b0;
      if (ifc.rf_wr_en_out) stub_mem[ifc.rf_addr_out] <= ifc.rf_wr_data_out;
      if (stub_cnt == 1) begin
         ifc.rf_rd_data_valid_in <= 1'b1;
         ifc.rf_rd_data_in       <= stub_mem[stub_addr];
      end
      if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
      if (ifc.rf_rd_en_out && !rf_never) begin
         if (rd_lat <= 1) begin
            ifc.rf_rd_data_valid_in <= 1'b1;
            ifc.rf_rd_data_in       <= stub_mem[ifc.rf_addr_out];
         end else begin
            stub_cnt  <= rd_lat - 1;
            stub_addr <= ifc.rf_addr_out;
         end
      end
   end

   // monitor
   logic [11:0] wr_q [$];
   logic [7:0]  tx_q [$];
   int n_wr = 0, n_rd = 0, n_errp = 0, n_both = 0, n_err_long = 0;
   logic prev_err = 1'b0;

   always @(negedge clk) begin
      if (ifc.rf_wr_en_out === 1'b1) begin
         n_wr++;
         wr_q.push_back({ifc.rf_addr_out, ifc.rf_wr_data_out});
      end
      if (ifc.rf_rd_en_out === 1'b1) n_rd++;
      if (ifc.rf_wr_en_out === 1'b1 && ifc.rf_rd_en_out === 1'b1) n_both++;
      if (ifc.err_out === 1'b1) begin
         n_errp++;
         if (prev_err) n_err_long++;
      end
      prev_err = (ifc.err_out === 1'b1);
      if (ifc.tx_valid_out === 1'b1 && ifc.tx_ready_in === 1'b1) tx_q.push_back(ifc.tx_data_out);
   end

   logic [7:0] model_mem [16] = '{default: 8'h00};

   initial begin
      #2ms;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [24:0] outs();
      return {ifc.rf_wr_en_out, ifc.rf_rd_en_out, ifc.rf_addr_out, ifc.rf_wr_data_out,
              ifc.tx_data_out, ifc.tx_valid_out, ifc.busy_out, ifc.err_out};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      ifc.rx_data_in  = b;
      ifc.rx_valid_in = 1'b1;
      cyc(1);
      ifc.rx_valid_in = 1'b0;
   endtask

   task automatic test_reset;
      cyc(2);
      n_cmp++;
      if (outs() !== 25'h0) begin
         n_mis++; $display("FAIL reset_hold: got %h expected %h", outs(), 25'h0);
      end
      reset_n = 1'b1;
      cyc(2);
      n_cmp++;
      if (outs() !== 25'h0) begin
         n_mis++; $display("FAIL reset_idle: got %h expected %h", outs(), 25'h0);
      end
   endtask

   task automatic test_write;
      int w0 = n_wr, r0 = n_rd, e0 = n_errp, q0 = wr_q.size();
      send_byte(8'hAA);
      n_cmp++;
      if (ifc.busy_out !== 1'b1) begin
         n_mis++; $display("FAIL wr_busy: got %b expected 1", ifc.busy_out);
      end
      send_byte(8'h05);
      send_byte(8'h3C);
      model_mem[5] = 8'h3C;
      n_cmp++;
      if ({ifc.rf_wr_en_out, ifc.rf_rd_en_out, ifc.busy_out, ifc.rf_addr_out, ifc.rf_wr_data_out} !== {3'b100, 4'h5, 8'h3C}) begin
         n_mis++; $display("FAIL wr_pulse: got we=%b re=%b busy=%b a=%h d=%h expected we=1 re=0 busy=0 a=5 d=3c",
                           ifc.rf_wr_en_out, ifc.rf_rd_en_out, ifc.busy_out, ifc.rf_addr_out, ifc.rf_wr_data_out);
      end
      cyc(3);
      n_cmp++;
      if (n_wr - w0 != 1 || n_rd - r0 != 0 || n_errp - e0 != 0 || wr_q.size() != q0 + 1) begin
         n_mis++; $display("FAIL wr_counts: got wr=%0d rd=%0d err=%0d expected 1 0 0", n_wr - w0, n_rd - r0, n_errp - e0);
      end else begin
         n_cmp++;
         if (wr_q[q0] !== {4'h5, 8'h3C}) begin
            n_mis++; $display("FAIL wr_entry: got %h expected %h", wr_q[q0], {4'h5, 8'h3C});
         end
      end
   endtask

   task automatic test_read;
      int t0, r0, k;
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h21);
      model_mem[2] = 8'h21;
      cyc(2);
      ifc.tx_ready_in = 1'b1;
      rd_lat = 1;
      t0 = tx_q.size(); r0 = n_rd;
      send_byte(8'hBB); send_byte(8'h02);
      n_cmp++;
      if ({ifc.rf_rd_en_out, ifc.rf_wr_en_out, ifc.rf_addr_out} !== {2'b10, 4'h2}) begin
         n_mis++; $display("FAIL rd_pulse: got re=%b we=%b a=%h expected re=1 we=0 a=2",
                           ifc.rf_rd_en_out, ifc.rf_wr_en_out, ifc.rf_addr_out);
      end
      k = 0;
      while (tx_q.size() == t0 && k < 20) begin cyc(1); k++; end
      n_cmp++;
      if (tx_q.size() == t0) begin
         n_mis++; $display("FAIL rd_tx_timeout: got no tx byte expected 21");
      end else begin
         n_cmp++;
         if (tx_q[t0] !== 8'h21 || ifc.tx_valid_out !== 1'b0 || ifc.busy_out !== 1'b0 || n_rd - r0 != 1) begin
            n_mis++; $display("FAIL rd_tx: got byte=%h valid=%b busy=%b rds=%0d expected 21 0 0 1",
                              tx_q[t0], ifc.tx_valid_out, ifc.busy_out, n_rd - r0);
         end
      end
   endtask

   task automatic test_backpressure;
      int k, bad;
      ifc.tx_ready_in = 1'b0;
      send_byte(8'hAA); send_byte(8'h07); send_byte(8'h5A);
      model_mem[7] = 8'h5A;
      cyc(1);
      rd_lat = 3;
      send_byte(8'hBB); send_byte(8'h07);
      k = 0;
      while (ifc.tx_valid_out !== 1'b1 && k < 20) begin cyc(1); k++; end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (ifc.tx_valid_out !== 1'b1 || ifc.tx_data_out !== 8'h5A) bad++;
         cyc(1);
      end
      n_cmp++;
      if (bad != 0) begin
         n_mis++; $display("FAIL bp_hold: got %0d unstable cycles (last valid=%b data=%h) expected 0 (valid=1 data=5a)",
                           bad, ifc.tx_valid_out, ifc.tx_data_out);
      end
      ifc.tx_ready_in = 1'b1;
      cyc(1);
      n_cmp++;
      if (ifc.tx_valid_out !== 1'b0 || ifc.tx_data_out !== 8'h5A || ifc.busy_out !== 1'b0) begin
         n_mis++; $display("FAIL bp_drop: got valid=%b data=%h busy=%b expected 0 5a 0",
                           ifc.tx_valid_out, ifc.tx_data_out, ifc.busy_out);
      end
   endtask

   task automatic test_bad_opcode;
      int w0 = n_wr, r0 = n_rd, e0 = n_errp, l0 = n_err_long, q0 = wr_q.size();
      send_byte(8'h55);
      n_cmp++;
      if (ifc.err_out !== 1'b1 || ifc.busy_out !== 1'b0) begin
         n_mis++; $display("FAIL bad_err: got err=%b busy=%b expected 1 0", ifc.err_out, ifc.busy_out);
      end
      cyc(1);
      n_cmp++;
      if (ifc.err_out !== 1'b0) begin
         n_mis++; $display("FAIL bad_err_len: got err=%b expected 0", ifc.err_out);
      end
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'hFF);
      model_mem[1] = 8'hFF;
      cyc(2);
      n_cmp++;
      if (n_wr - w0 != 1 || n_rd - r0 != 0 || n_errp - e0 != 1 || n_err_long != l0 || wr_q.size() != q0 + 1) begin
         n_mis++; $display("FAIL bad_counts: got wr=%0d rd=%0d err=%0d expected 1 0 1", n_wr - w0, n_rd - r0, n_errp - e0);
      end else begin
         n_cmp++;
         if (wr_q[q0] !== {4'h1, 8'hFF}) begin
            n_mis++; $display("FAIL bad_then_wr: got %h expected %h", wr_q[q0], {4'h1, 8'hFF});
         end
      end
   endtask

   task automatic test_reset_midframe;
      int w0 = n_wr, r0 = n_rd, e0;
      send_byte(8'hAA); send_byte(8'h03);
      n_cmp++;
      if (ifc.busy_out !== 1'b1) begin
         n_mis++; $display("FAIL mid_busy: got %b expected 1", ifc.busy_out);
      end
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (outs() !== 25'h0) begin
         n_mis++; $display("FAIL mid_reset: got %h expected %h", outs(), 25'h0);
      end
      cyc(2);
      reset_n = 1'b1;
      cyc(1);
      e0 = n_errp;
      send_byte(8'h7E);
      n_cmp++;
      if (ifc.err_out !== 1'b1) begin
         n_mis++; $display("FAIL mid_err: got %b expected 1", ifc.err_out);
      end
      cyc(3);
      n_cmp++;
      if (n_wr - w0 != 0 || n_rd - r0 != 0 || n_errp - e0 != 1 || ifc.busy_out !== 1'b0) begin
         n_mis++; $display("FAIL mid_counts: got wr=%0d rd=%0d err=%0d busy=%b expected 0 0 1 0",
                           n_wr - w0, n_rd - r0, n_errp - e0, ifc.busy_out);
      end
   endtask

   task automatic test_dropped_byte;
      int w0 = n_wr, e0 = n_errp, k;
      ifc.tx_ready_in = 1'b0;
      rd_lat = 4;
      send_byte(8'hAA); send_byte(8'h09); send_byte(8'hC3);
      model_mem[9] = 8'hC3;
      cyc(1);
      send_byte(8'hBB); send_byte(8'h09);
      cyc(1);
      send_byte(8'h12);
      n_cmp++;
      if (ifc.err_out !== 1'b1 || ifc.busy_out !== 1'b1) begin
         n_mis++; $display("FAIL drop_rwait: got err=%b busy=%b expected 1 1", ifc.err_out, ifc.busy_out);
      end
      k = 0;
      while (ifc.tx_valid_out !== 1'b1 && k < 20) begin cyc(1); k++; end
      n_cmp++;
      if (ifc.tx_valid_out !== 1'b1 || ifc.tx_data_out !== 8'hC3) begin
         n_mis++; $display("FAIL drop_rdata: got valid=%b data=%h expected 1 c3", ifc.tx_valid_out, ifc.tx_data_out);
      end
      send_byte(8'hAA);
      n_cmp++;
      if (ifc.err_out !== 1'b1 || ifc.tx_valid_out !== 1'b1 || ifc.tx_data_out !== 8'hC3) begin
         n_mis++; $display("FAIL drop_tx: got err=%b valid=%b data=%h expected 1 1 c3",
                           ifc.err_out, ifc.tx_valid_out, ifc.tx_data_out);
      end
      ifc.tx_ready_in = 1'b1;
      cyc(2);
      send_byte(8'h05);
      n_cmp++;
      if (ifc.err_out !== 1'b1 || ifc.busy_out !== 1'b0) begin
         n_mis++; $display("FAIL drop_idle_after: got err=%b busy=%b expected 1 0", ifc.err_out, ifc.busy_out);
      end
      cyc(2);
      n_cmp++;
      if (n_wr - w0 != 1 || n_errp - e0 != 3) begin
         n_mis++; $display("FAIL drop_counts: got wr=%0d err=%0d expected 1 3", n_wr - w0, n_errp - e0);
      end
   endtask

   task automatic test_back_to_back;
      int e0 = n_errp, q0 = wr_q.size(), t0 = tx_q.size(), k;
      ifc.tx_ready_in = 1'b1;
      rd_lat = 2;
      send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h11);
      send_byte(8'hAA); send_byte(8'h0B); send_byte(8'h22);
      send_byte(8'hBB); send_byte(8'h0A);
      model_mem[10] = 8'h11; model_mem[11] = 8'h22;
      k = 0;
      while (tx_q.size() == t0 && k < 20) begin cyc(1); k++; end
      cyc(1);
      n_cmp++;
      if (wr_q.size() != q0 + 2 || tx_q.size() != t0 + 1 || n_errp != e0) begin
         n_mis++; $display("FAIL b2b_counts: got wr=%0d tx=%0d err=%0d expected 2 1 0",
                           wr_q.size() - q0, tx_q.size() - t0, n_errp - e0);
      end else begin
         n_cmp++;
         if ({wr_q[q0], wr_q[q0+1], tx_q[t0]} !== {4'hA, 8'h11, 4'hB, 8'h22, 8'h11}) begin
            n_mis++; $display("FAIL b2b_data: got %h %h %h expected a11 b22 11", wr_q[q0], wr_q[q0+1], tx_q[t0]);
         end
      end
   endtask

`ifdef CTRL_TIMEOUT_EN
   task automatic test_timeout;
      int k;
      rf_never = 1'b1;
      ifc.tx_ready_in = 1'b0;
      send_byte(8'hBB); send_byte(8'h04);
      k = 0;
      while (ifc.tx_valid_out !== 1'b1 && k < 40) begin cyc(1); k++; end
      n_cmp++;
      if (k != 16 || ifc.tx_data_out !== 8'hEE || ifc.err_out !== 1'b1) begin
         n_mis++; $display("FAIL timeout: got cycles=%0d data=%h err=%b expected 16 ee 1", k, ifc.tx_data_out, ifc.err_out);
      end
      rf_never = 1'b0;
      ifc.tx_ready_in = 1'b1;
      cyc(2);
      n_cmp++;
      if (ifc.busy_out !== 1'b0 || ifc.err_out !== 1'b0) begin
         n_mis++; $display("FAIL timeout_exit: got busy=%b err=%b expected 0 0", ifc.busy_out, ifc.err_out);
      end
   endtask
`else
   task automatic test_no_timeout;
      rf_never = 1'b1;
      ifc.tx_ready_in = 1'b1;
      send_byte(8'hBB); send_byte(8'h04);
      cyc(40);
      n_cmp++;
      if (ifc.tx_valid_out !== 1'b0 || ifc.busy_out !== 1'b1 || ifc.err_out !== 1'b0) begin
         n_mis++; $display("FAIL no_timeout: got valid=%b busy=%b err=%b expected 0 1 0",
                           ifc.tx_valid_out, ifc.busy_out, ifc.err_out);
      end
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      rf_never = 1'b0;
      cyc(2);
   endtask
`endif

   task automatic test_random;
      logic [11:0] exp_wr [$];
      logic [7:0]  exp_tx [$];
      int exp_err = 0, hangs = 0, k, kind;
      int q0 = wr_q.size(), t0 = tx_q.size(), e0 = n_errp;
      logic [3:0] a;
      logic [7:0] d, b;
      for (int f = 0; f < 60; f++) begin
         kind = $urandom_range(0, 2);
         a = 4'($urandom_range(0, 15));
         if (kind == 0) begin
            d = 8'($urandom_range(0, 255));
            exp_wr.push_back({a, d});
            model_mem[a] = d;
            send_byte(8'hAA); cyc($urandom_range(0, 2));
            send_byte({4'($urandom_range(0, 15)), a}); cyc($urandom_range(0, 2));
            send_byte(d);
         end else if (kind == 1) begin
            exp_tx.push_back(model_mem[a]);
            rd_lat = $urandom_range(1, 4);
            send_byte(8'hBB); cyc($urandom_range(0, 2));
            send_byte({4'($urandom_range(0, 15)), a});
            k = 0;
            while (ifc.busy_out !== 1'b0 && k < 100) begin
               ifc.tx_ready_in = 1'($urandom_range(0, 1));
               cyc(1);
               k++;
            end
            if (k >= 100) hangs++;
         end else begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hAA || b == 8'hBB);
            exp_err++;
            send_byte(b);
         end
         cyc($urandom_range(0, 2));
      end
      cyc(4);
      n_cmp++;
      if (hangs != 0) begin
         n_mis++; $display("FAIL rnd_hang: got %0d stuck reads expected 0", hangs);
      end
      n_cmp++;
      if (wr_q.size() - q0 != exp_wr.size() || tx_q.size() - t0 != exp_tx.size() || n_errp - e0 != exp_err) begin
         n_mis++; $display("FAIL rnd_counts: got wr=%0d tx=%0d err=%0d expected %0d %0d %0d",
                           wr_q.size() - q0, tx_q.size() - t0, n_errp - e0, exp_wr.size(), exp_tx.size(), exp_err);
      end
      for (int i = 0; i < exp_wr.size() && q0 + i < wr_q.size(); i++) begin
         n_cmp++;
         if (wr_q[q0+i] !== exp_wr[i]) begin
            n_mis++; $display("FAIL rnd_wr[%0d]: got %h expected %h", i, wr_q[q0+i], exp_wr[i]);
         end
      end
      for (int i = 0; i < exp_tx.size() && t0 + i < tx_q.size(); i++) begin
         n_cmp++;
         if (tx_q[t0+i] !== exp_tx[i]) begin
            n_mis++; $display("FAIL rnd_tx[%0d]: got %h expected %h", i, tx_q[t0+i], exp_tx[i]);
         end
      end
      n_cmp++;
      if (n_both != 0) begin
         n_mis++; $display("FAIL en_exclusive: got %0d cycles with both enables expected 0", n_both);
      end
   endtask

   initial begin
      ifc.rx_data_in  = 8'h00;
      ifc.rx_valid_in = 1'b0;
      ifc.tx_ready_in = 1'b0;
      test_reset;
      test_write;
      test_read;
      test_backpressure;
      test_bad_opcode;
      test_reset_midframe;
      test_dropped_byte;
      test_back_to_back;
`ifdef CTRL_TIMEOUT_EN
      test_timeout;
`else
      test_no_timeout;
`endif
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
